// File: rtl/fft64_transpose_buffer.sv
// Ping-pong 2x64-word complex buffer: writes a 64-sample frame in natural order and
// replays it with the address digits swapped. Define FFT64_BUF_NATURAL_EN for natural-order readout.
module fft64_transpose_buffer #(
   parameter int NB = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ED,
   input  logic                 START,
   input  logic signed [NB+1:0] DR,
   input  logic signed [NB+1:0] DI,
   output logic signed [NB+1:0] DOR,
   output logic signed [NB+1:0] DOI,
   output logic                 RDY
);

   localparam int W = NB + 2;

   // Write side
   logic [5:0]     wcnt_reg, wcnt_next;
   logic           wbank_reg, wbank_next;
   logic           armed_reg, armed_next;
   // Read side
   logic [5:0]     rcnt_reg, rcnt_next;
   logic           rbank_reg, rbank_next;
   logic           rd_active_reg, rd_active_next;
   logic           rdy_reg, rdy_next;

   logic           wr_en;
   logic           frame_done;
   logic           rd_en;
   logic [6:0]     wr_addr;
   logic [6:0]     rd_addr;
   logic [5:0]     rd_word;
   logic [2*W-1:0] rd_data_reg;

   logic [2*W-1:0] mem [0:127];

   // A START cycle never carries a sample, and it also pre-empts completion of addr 63.
   assign wr_en      = ED && armed_reg && !START;
   assign frame_done = wr_en && (wcnt_reg == 6'd63);
   assign rd_en      = ED && rd_active_reg;
   assign wr_addr    = {wbank_reg, wcnt_reg};
   assign rd_addr    = {rbank_reg, rd_word};

`ifdef FFT64_BUF_NATURAL_EN
   assign rd_word = rcnt_reg;
`else
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_transpose
         assign rd_word[gi]     = rcnt_reg[gi+3];
         assign rd_word[gi + 3] = rcnt_reg[gi];
      end
   endgenerate
`endif

   always_comb begin
      wcnt_next      = wcnt_reg;
      wbank_next     = wbank_reg;
      armed_next     = armed_reg;
      rcnt_next      = rcnt_reg;
      rbank_next     = rbank_reg;
      rd_active_next = rd_active_reg;
      rdy_next       = rdy_reg;

      if (ED) begin
         if (START) begin
            wcnt_next  = 6'd0;
            armed_next = 1'b1;
         end else if (armed_reg) begin
            wcnt_next = wcnt_reg + 6'd1;
         end

         rdy_next = frame_done;

         // A freshly completed bank takes over reading; the old bank's last word
         // is read on this same cycle, so there is no gap between frames.
         if (frame_done) begin
            wbank_next     = ~wbank_reg;
            rbank_next     = wbank_reg;
            rd_active_next = 1'b1;
            rcnt_next      = 6'd0;
         end else if (rd_active_reg) begin
            rcnt_next = rcnt_reg + 6'd1;
            if (rcnt_reg == 6'd63) begin
               rd_active_next = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wcnt_reg      <= 6'd0;
         wbank_reg     <= 1'b0;
         armed_reg     <= 1'b0;
         rcnt_reg      <= 6'd0;
         rbank_reg     <= 1'b0;
         rd_active_reg <= 1'b0;
         rdy_reg       <= 1'b0;
      end else begin
         wcnt_reg      <= wcnt_next;
         wbank_reg     <= wbank_next;
         armed_reg     <= armed_next;
         rcnt_reg      <= rcnt_next;
         rbank_reg     <= rbank_next;
         rd_active_reg <= rd_active_next;
         rdy_reg       <= rdy_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= {DR, DI};
      end
   end

   // The registered RAM read doubles as the output register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign DOR = rd_data_reg[2*W-1:W];
   assign DOI = rd_data_reg[W-1:0];
   assign RDY = rdy_reg;

endmodule
